inst_sequencer: RTL and testbench
=================================

# inst_sequencer

Multi-cycle control FSM for the RV32I core: sequences fetch, decode, execute, memory and writeback around the combinational `decode` block. It drives instruction-register, register-file, PC and memory-bus enables. It consumes `decode`'s `opcode` and `invalid` outputs, the branch comparator result and the memory handshake. Illegal instructions, SYSTEM instructions and memory timeouts trap to a halt state.

## Interface
- `MEM_TIMEOUT`, default 15: extra wait cycles allowed per memory request before a bus-timeout trap; must be at least 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `opcode` in 7: `inst[6:0]` from `decode`, driven from the IR.
- `invalid` in 1: `decode` illegal-instruction flag.
- `branch_taken` in 1: branch comparator result, valid in EXEC.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = store.
- `mem_is_fetch` out 1: address mux select; 1 = PC, 0 = ALU result.
- `ir_we` out 1: latch fetched word into the IR.
- `rf_we` out 1: register-file write; the datapath ignores writes to x0.
- `wb_sel` out 2: writeback source; 00 = ALU, 01 = memory, 10 = PC+4.
- `alu_a_pc` out 1: ALU A operand = PC (AUIPC, JAL, BRANCH).
- `alu_b_imm` out 1: ALU B operand = imm (every opcode except OP).
- `pc_we` out 1: PC update.
- `pc_sel` out 1: next PC; 0 = PC+4, 1 = ALU result.
- `trap` out 1: one-cycle pulse on entry to HALT.
- `trap_cause` out 2: 01 = illegal, 10 = bus timeout, 11 = SYSTEM.
- `halt` out 1: core halted.
- `state` out 3: current state, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- Opcodes used:
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111
  - BRANCH 1100011, LOAD 0000011, STORE 0100011
  - OP-IMM 0010011, OP 0110011, MISC-MEM 0001111, SYSTEM 1110011
- FETCH: `mem_req`=1, `mem_is_fetch`=1, `mem_we`=0.
  - On `mem_ready`: `ir_we`=1 in the same cycle, next state DECODE.
- DECODE: one cycle, all enables 0.
  - `invalid`=1 -> HALT, cause 01.
  - Else SYSTEM -> HALT, cause 11.
  - Else -> EXEC.
- EXEC: one cycle.
  - LOAD, STORE -> MEM.
  - BRANCH: `pc_we`=1, `pc_sel`=`branch_taken`, next state FETCH.
  - MISC-MEM (FENCE is a no-op): `pc_we`=1, `pc_sel`=0, next state FETCH.
  - All other opcodes -> WB.
- MEM: `mem_req`=1, `mem_is_fetch`=0, `mem_we`=1 for STORE only.
  - STORE with `mem_ready`: `pc_we`=1, `pc_sel`=0, next state FETCH.
  - LOAD with `mem_ready`: next state WB.
- WB: `rf_we`=1, `pc_we`=1.
  - `wb_sel`: 01 for LOAD, 10 for JAL/JALR, else 00.
  - `pc_sel`=1 for JAL/JALR, else 0.
  - The old PC feeds PC+4 in this cycle; the PC updates at the edge. Next state FETCH.
- `alu_a_pc` and `alu_b_imm` are combinational from `opcode` in DECODE, EXEC, MEM and WB; 0 elsewhere.
- Timeout counter, `$clog2(MEM_TIMEOUT+1)` bits:
  - Cleared to 0 on entry to FETCH or MEM.
  - Increments each request cycle without `mem_ready`.
  - `mem_ready`=0 while the count equals `MEM_TIMEOUT` -> HALT, cause 10.
  - `mem_ready` in that same cycle wins: normal completion, no trap.
- HALT: all enables 0, `halt`=1, `trap_cause` held. Exit only by reset.

## Timing
- Reset with `rst_n`=0 at an edge:
  - Next state FETCH, counter 0.
  - `trap`=0, `trap_cause`=00, `halt`=0, `state`=0.
- While `rst_n`=0, every combinational enable (`mem_req`, `mem_we`, `mem_is_fetch`, `ir_we`, `rf_we`, `pc_we`, `pc_sel`, `wb_sel`, `alu_*`) is forced to 0 in the same cycle. This holds even mid-request.
- The first `mem_req` appears in the first cycle with `rst_n`=1.
- `trap`, `trap_cause` and `halt` are registered; they assert in the first HALT cycle. `trap` is high for exactly that one cycle.
- Latency with zero-wait memory (`mem_ready` in the first request cycle):
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles. STORE: 4 cycles. BRANCH and FENCE: 3 cycles.
  - Each wait cycle adds 1.
- A memory request can stay asserted for at most `MEM_TIMEOUT`+1 cycles.
- `mem_req` never drops before `mem_ready` unless a timeout or reset occurs.

## Test plan
- ADDI (`opcode`=0010011), `mem_ready` always 1 -> states 0,1,2,4; `ir_we` in cycle 0; `rf_we`=1, `pc_we`=1, `pc_sel`=0 and `wb_sel`=00 in cycle 3.
- LOAD, data `mem_ready` delayed 3 cycles -> MEM holds `mem_req`=1, `mem_is_fetch`=0 for 4 cycles; then WB with `wb_sel`=01; total 8 cycles.
- BRANCH with `branch_taken`=1, then with `branch_taken`=0 -> EXEC gives `pc_we`=1 with `pc_sel`=1, then 0; back to FETCH after 3 cycles, `rf_we` never asserted.
- `invalid`=1 in DECODE -> HALT; `trap` pulses 1 cycle, `trap_cause`=01, `halt`=1; nothing leaves HALT until reset. Repeat with `opcode`=1110011 -> cause 11.
- `MEM_TIMEOUT`=15, `mem_ready` held 0 in FETCH -> `mem_req` high 16 cycles, then HALT with cause 10. Repeat with `mem_ready`=1 on the 16th cycle -> DECODE, no trap.
- `rst_n`=0 mid-MEM with a STORE in progress -> `mem_req` and `mem_we` drop the same cycle; `state`=0 next cycle; a fresh fetch starts on release.

Source files
------------

// File: rtl/inst_sequencer_if.sv
// Control/status bundle between the RV32I multi-cycle sequencer and its datapath.
// The sequencer takes the master modport; the datapath and memory side take the slave.
interface inst_sequencer_if;
  logic [6:0] opcode;
  logic       invalid;
  logic       branch_taken;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       mem_is_fetch;
  logic       ir_we;
  logic       rf_we;
  logic [1:0] wb_sel;
  logic       alu_a_pc;
  logic       alu_b_imm;
  logic       pc_we;
  logic       pc_sel;
  logic       trap;
  logic [1:0] trap_cause;
  logic       halt;
  logic [2:0] state;

  modport master (
    input  opcode, invalid, branch_taken, mem_ready,
    output mem_req, mem_we, mem_is_fetch, ir_we, rf_we, wb_sel,
           alu_a_pc, alu_b_imm, pc_we, pc_sel, trap, trap_cause, halt, state
  );

  modport slave (
    output opcode, invalid, branch_taken, mem_ready,
    input  mem_req, mem_we, mem_is_fetch, ir_we, rf_we, wb_sel,
           alu_a_pc, alu_b_imm, pc_we, pc_sel, trap, trap_cause, halt, state
  );
endinterface

// File: rtl/inst_sequencer.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB, 3-5 cycles per instruction plus memory waits.
// Memory stalls hold the request until mem_ready; a stall longer than MEM_TIMEOUT traps to HALT.
module inst_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  inst_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam int              CW      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(MEM_TIMEOUT);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            trap_q, trap_d;
  logic [1:0]      trap_cause_q, trap_cause_d;
  logic            halt_q, halt_d;

  logic is_load, is_store, is_jump;
  logic timed_out;

  assign is_load   = (bus.opcode == OPC_LOAD);
  assign is_store  = (bus.opcode == OPC_STORE);
  assign is_jump   = (bus.opcode == OPC_JAL) || (bus.opcode == OPC_JALR);
  assign timed_out = !bus.mem_ready && (cnt_q == CNT_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      cnt_q        <= '0;
      trap_q       <= 1'b0;
      trap_cause_q <= 2'b00;
      halt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      trap_q       <= trap_d;
      trap_cause_q <= trap_cause_d;
      halt_q       <= halt_d;
    end
  end

  // Next-state logic; the counter falls back to 0 in every cycle that is not a stalled request,
  // so it is already clear whenever FETCH or MEM is entered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    trap_cause_d = trap_cause_q;
    unique case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) begin
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d      = S_HALT;
          trap_cause_d = CAUSE_BUS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE: begin
        if (bus.invalid) begin
          state_d      = S_HALT;
          trap_cause_d = CAUSE_ILLEGAL;
        end else if (bus.opcode == OPC_SYSTEM) begin
          state_d      = S_HALT;
          trap_cause_d = CAUSE_SYSTEM;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (bus.opcode == OPC_BRANCH || bus.opcode == OPC_MISC) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          state_d = is_store ? S_FETCH : S_WB;
        end else if (timed_out) begin
          state_d      = S_HALT;
          trap_cause_d = CAUSE_BUS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    halt_d = (state_d == S_HALT);
    trap_d = (state_d == S_HALT) && (state_q != S_HALT);
  end

  logic       mem_req_c, mem_we_c, mem_is_fetch_c, ir_we_c, rf_we_c;
  logic       pc_we_c, pc_sel_c, alu_a_pc_c, alu_b_imm_c;
  logic [1:0] wb_sel_c;

  // Output logic; holding reset kills every enable immediately, even mid-request.
  always_comb begin
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_is_fetch_c = 1'b0;
    ir_we_c        = 1'b0;
    rf_we_c        = 1'b0;
    pc_we_c        = 1'b0;
    pc_sel_c       = 1'b0;
    wb_sel_c       = WB_ALU;
    alu_a_pc_c     = 1'b0;
    alu_b_imm_c    = 1'b0;
    if (rst_n) begin
      if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
        alu_a_pc_c  = (bus.opcode == OPC_AUIPC) || (bus.opcode == OPC_JAL) ||
                      (bus.opcode == OPC_BRANCH);
        alu_b_imm_c = (bus.opcode != OPC_OP);
      end
      unique case (state_q)
        S_FETCH: begin
          mem_req_c      = 1'b1;
          mem_is_fetch_c = 1'b1;
          ir_we_c        = bus.mem_ready;
        end
        S_EXEC: begin
          if (bus.opcode == OPC_BRANCH) begin
            pc_we_c  = 1'b1;
            pc_sel_c = bus.branch_taken;
          end else if (bus.opcode == OPC_MISC) begin
            pc_we_c = 1'b1;
          end
        end
        S_MEM: begin
          mem_req_c = 1'b1;
          mem_we_c  = is_store;
          pc_we_c   = is_store && bus.mem_ready;
        end
        S_WB: begin
          rf_we_c  = 1'b1;
          pc_we_c  = 1'b1;
          pc_sel_c = is_jump;
          wb_sel_c = is_load ? WB_MEM : (is_jump ? WB_PC4 : WB_ALU);
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req      = mem_req_c;
  assign bus.mem_we       = mem_we_c;
  assign bus.mem_is_fetch = mem_is_fetch_c;
  assign bus.ir_we        = ir_we_c;
  assign bus.rf_we        = rf_we_c;
  assign bus.wb_sel       = wb_sel_c;
  assign bus.alu_a_pc     = alu_a_pc_c;
  assign bus.alu_b_imm    = alu_b_imm_c;
  assign bus.pc_we        = pc_we_c;
  assign bus.pc_sel       = pc_sel_c;
  assign bus.trap         = trap_q;
  assign bus.trap_cause   = trap_cause_q;
  assign bus.halt         = halt_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: per-cycle state and enable vectors against hand-computed values.
module tb_inst_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inst_sequencer_if bus();

  inst_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Enable vector: {mem_req, mem_we, mem_is_fetch, ir_we, rf_we, pc_we, pc_sel, wb_sel[1:0], alu_a_pc, alu_b_imm}
  localparam logic [10:0] C_REQ  = 11'h400;
  localparam logic [10:0] C_WE   = 11'h200;
  localparam logic [10:0] C_FET  = 11'h100;
  localparam logic [10:0] C_IR   = 11'h080;
  localparam logic [10:0] C_RF   = 11'h040;
  localparam logic [10:0] C_PCW  = 11'h020;
  localparam logic [10:0] C_PCS  = 11'h010;
  localparam logic [10:0] C_WBP  = 11'h008;
  localparam logic [10:0] C_WBM  = 11'h004;
  localparam logic [10:0] C_APC  = 11'h002;
  localparam logic [10:0] C_BIMM = 11'h001;
  localparam logic [10:0] C_NONE = 11'h000;

  localparam logic [10:0] C_FETCH_OK = C_REQ | C_FET | C_IR;

  logic [10:0] ctl;
  assign ctl = {bus.mem_req, bus.mem_we, bus.mem_is_fetch, bus.ir_we, bus.rf_we, bus.pc_we,
                bus.pc_sel, bus.wb_sel, bus.alu_a_pc, bus.alu_b_imm};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One FSM cycle: drive mem_ready, let combinational outputs settle, check, advance.
  task automatic cyc(input string tag, input logic rdy, input logic [2:0] exp_state,
                     input logic [10:0] exp_ctl);
    bus.mem_ready = rdy;
    #1;
    check({tag, ".state"}, 32'(bus.state), 32'(exp_state));
    check({tag, ".ctl"},   32'(ctl),       32'(exp_ctl));
    tick();
  endtask

  task automatic chk_status(input string tag, input logic exp_trap, input logic [1:0] exp_cause,
                            input logic exp_halt);
    #1;
    check({tag, ".trap"},  32'(bus.trap),       32'(exp_trap));
    check({tag, ".cause"}, 32'(bus.trap_cause), 32'(exp_cause));
    check({tag, ".halt"},  32'(bus.halt),       32'(exp_halt));
  endtask

  task automatic do_reset(input string tag);
    rst_n         = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check({tag, ".rst_ctl"}, 32'(ctl), 32'(C_NONE));
    tick();
    tick();
    check({tag, ".rst_state"}, 32'(bus.state), 32'd0);
    chk_status({tag, ".rst"}, 1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.opcode       = 7'b0010011;
    bus.invalid      = 1'b0;
    bus.branch_taken = 1'b0;
    bus.mem_ready    = 1'b0;

    do_reset("r0");

    // ADDI, zero-wait: 4 cycles
    bus.opcode = 7'b0010011;
    cyc("addi0", 1'b1, 3'd0, C_FETCH_OK);
    cyc("addi1", 1'b1, 3'd1, C_BIMM);
    cyc("addi2", 1'b1, 3'd2, C_BIMM);
    cyc("addi3", 1'b1, 3'd4, C_RF | C_PCW | C_BIMM);

    // LOAD with 3 data wait cycles: 8 cycles total
    bus.opcode = 7'b0000011;
    cyc("ld0", 1'b1, 3'd0, C_FETCH_OK);
    cyc("ld1", 1'b1, 3'd1, C_BIMM);
    cyc("ld2", 1'b1, 3'd2, C_BIMM);
    for (int i = 0; i < 3; i++) cyc("ldw", 1'b0, 3'd3, C_REQ | C_BIMM);
    cyc("ld6", 1'b1, 3'd3, C_REQ | C_BIMM);
    cyc("ld7", 1'b1, 3'd4, C_RF | C_PCW | C_WBM | C_BIMM);

    // BRANCH taken then not taken: 3 cycles each, no rf_we
    bus.opcode       = 7'b1100011;
    bus.branch_taken = 1'b1;
    cyc("bt0", 1'b1, 3'd0, C_FETCH_OK);
    cyc("bt1", 1'b1, 3'd1, C_APC | C_BIMM);
    cyc("bt2", 1'b1, 3'd2, C_PCW | C_PCS | C_APC | C_BIMM);
    bus.branch_taken = 1'b0;
    cyc("bn0", 1'b1, 3'd0, C_FETCH_OK);
    cyc("bn1", 1'b1, 3'd1, C_APC | C_BIMM);
    cyc("bn2", 1'b1, 3'd2, C_PCW | C_APC | C_BIMM);

    // STORE, zero-wait: 4 cycles
    bus.opcode = 7'b0100011;
    cyc("st0", 1'b1, 3'd0, C_FETCH_OK);
    cyc("st1", 1'b1, 3'd1, C_BIMM);
    cyc("st2", 1'b1, 3'd2, C_BIMM);
    cyc("st3", 1'b1, 3'd3, C_REQ | C_WE | C_PCW | C_BIMM);

    // JAL writes PC+4 and redirects; A operand is PC
    bus.opcode = 7'b1101111;
    cyc("jal0", 1'b1, 3'd0, C_FETCH_OK);
    cyc("jal1", 1'b1, 3'd1, C_APC | C_BIMM);
    cyc("jal2", 1'b1, 3'd2, C_APC | C_BIMM);
    cyc("jal3", 1'b1, 3'd4, C_RF | C_PCW | C_PCS | C_WBP | C_APC | C_BIMM);

    // JALR: A operand is rs1
    bus.opcode = 7'b1100111;
    cyc("jalr0", 1'b1, 3'd0, C_FETCH_OK);
    cyc("jalr1", 1'b1, 3'd1, C_BIMM);
    cyc("jalr2", 1'b1, 3'd2, C_BIMM);
    cyc("jalr3", 1'b1, 3'd4, C_RF | C_PCW | C_PCS | C_WBP | C_BIMM);

    // OP: register B operand
    bus.opcode = 7'b0110011;
    cyc("op0", 1'b1, 3'd0, C_FETCH_OK);
    cyc("op1", 1'b1, 3'd1, C_NONE);
    cyc("op2", 1'b1, 3'd2, C_NONE);
    cyc("op3", 1'b1, 3'd4, C_RF | C_PCW);

    // FENCE: 3 cycles, PC+4
    bus.opcode = 7'b0001111;
    cyc("fn0", 1'b1, 3'd0, C_FETCH_OK);
    cyc("fn1", 1'b1, 3'd1, C_BIMM);
    cyc("fn2", 1'b1, 3'd2, C_PCW | C_BIMM);

    // Reset mid-MEM of a stalled STORE
    bus.opcode = 7'b0100011;
    cyc("sr0", 1'b1, 3'd0, C_FETCH_OK);
    cyc("sr1", 1'b1, 3'd1, C_BIMM);
    cyc("sr2", 1'b1, 3'd2, C_BIMM);
    cyc("sr3", 1'b0, 3'd3, C_REQ | C_WE | C_BIMM);
    rst_n = 1'b0;
    #1;
    check("sr_rst.ctl", 32'(ctl), 32'(C_NONE));
    check("sr_rst.state", 32'(bus.state), 32'd3);
    tick();
    check("sr_after.state", 32'(bus.state), 32'd0);
    rst_n      = 1'b1;
    bus.opcode = 7'b0010011;
    cyc("sr_f0", 1'b1, 3'd0, C_FETCH_OK);
    cyc("sr_f1", 1'b1, 3'd1, C_BIMM);
    cyc("sr_f2", 1'b1, 3'd2, C_BIMM);
    cyc("sr_f3", 1'b1, 3'd4, C_RF | C_PCW | C_BIMM);

    // Fetch completing on the 16th (last allowed) request cycle: no trap
    for (int i = 0; i < 15; i++) cyc("tw", 1'b0, 3'd0, C_REQ | C_FET);
    cyc("tw15", 1'b1, 3'd0, C_FETCH_OK);
    check("tw_dec.state", 32'(bus.state), 32'd1);
    chk_status("tw_dec", 1'b0, 2'b00, 1'b0);
    cyc("tw_d", 1'b1, 3'd1, C_BIMM);
    cyc("tw_e", 1'b1, 3'd2, C_BIMM);
    cyc("tw_w", 1'b1, 3'd4, C_RF | C_PCW | C_BIMM);

    // Fetch never completes: 16 request cycles then bus-timeout trap
    for (int i = 0; i < 16; i++) cyc("to", 1'b0, 3'd0, C_REQ | C_FET);
    check("to_h.state", 32'(bus.state), 32'd7);
    check("to_h.ctl", 32'(ctl), 32'(C_NONE));
    chk_status("to_h0", 1'b1, 2'b10, 1'b1);
    bus.mem_ready = 1'b1;
    tick();
    chk_status("to_h1", 1'b0, 2'b10, 1'b1);
    check("to_h1.state", 32'(bus.state), 32'd7);

    // Illegal instruction
    do_reset("r1");
    bus.opcode  = 7'b0010011;
    bus.invalid = 1'b1;
    cyc("il0", 1'b1, 3'd0, C_FETCH_OK);
    cyc("il1", 1'b1, 3'd1, C_BIMM);
    check("il_h.state", 32'(bus.state), 32'd7);
    chk_status("il_h0", 1'b1, 2'b01, 1'b1);
    bus.invalid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("il_h3.state", 32'(bus.state), 32'd7);
    check("il_h3.ctl", 32'(ctl), 32'(C_NONE));
    chk_status("il_h3", 1'b0, 2'b01, 1'b1);

    // SYSTEM instruction
    do_reset("r2");
    bus.opcode = 7'b1110011;
    cyc("sy0", 1'b1, 3'd0, C_FETCH_OK);
    cyc("sy1", 1'b1, 3'd1, C_BIMM);
    check("sy_h.state", 32'(bus.state), 32'd7);
    chk_status("sy_h0", 1'b1, 2'b11, 1'b1);
    tick();
    chk_status("sy_h1", 1'b0, 2'b11, 1'b1);

    do_reset("r3");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
